// File: rtl/mux_nx1_stream.sv
// rtl/mux_nx1_stream.sv - registered N-channel stream multiplexer with fixed or round-robin select
//
// Purpose:
//   Picks one of N_CH valid/ready producer streams per beat and registers the
//   beat into a single output slot. The channel is chosen in one of two ways:
//     - fixed mode: the channel given on sel_in
//     - round-robin mode: a rotating search that starts after the last granted channel
//   The output slot can drain and refill on the same edge, so the mux sustains
//   one beat per cycle.
//
// Ports:
//   clk_in       rising-edge clock
//   rst_n_in     asynchronous active-low reset
//   mode_in      0 = fixed select via sel_in, 1 = round-robin
//   sel_in       channel index used in fixed mode
//   d_valid_in   per-channel valid
//   d_in         packed channel data, channel i at [i*WIDTH +: WIDTH]
//   d_ready_out  per-channel ready, one-hot or zero
//   d_valid_out  output beat valid
//   d_out        output beat data
//   ch_out       source channel of the output beat
//   d_ready_in   consumer ready

module mux_nx1_stream #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  mode_in,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [N_CH-1:0]       d_valid_in,
  input  logic [N_CH*WIDTH-1:0] d_in,
  output logic [N_CH-1:0]       d_ready_out,
  output logic                  d_valid_out,
  output logic [WIDTH-1:0]      d_out,
  output logic [SEL_W-1:0]      ch_out,
  input  logic                  d_ready_in
);

  // Round-robin pointer: index of the most recently granted channel.
  logic [SEL_W-1:0] ptr;

  // Unpacked view of the channel data, so selection is a plain array read.
  logic [WIDTH-1:0] ch_data [N_CH];

  logic             space;
  logic             fx_valid;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_g;
  logic [SEL_W-1:0] g;
  logic             grant_valid;
  logic             take;
  logic [WIDTH-1:0] g_data;

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_data[i] = d_in[i*WIDTH +: WIDTH];
  end

  // The slot can accept a beat when it is empty or is being drained right now.
  assign space = !d_valid_out || d_ready_in;

  // Fixed-mode grant. An index beyond the last channel never grants, which
  // only matters when N_CH is not a power of two.
  always_comb begin
    fx_valid = 1'b0;
    if (int'(sel_in) < N_CH) begin
      fx_valid = d_valid_in[sel_in];
    end
  end

  // Round-robin search over ptr+1, ptr+2, ... ptr+N_CH (mod N_CH). The loop
  // runs from the farthest candidate to the nearest, so the nearest valid
  // channel is written last and wins.
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] cand;
    rr_g     = '0;
    idx      = 0;
    cand     = '0;
    rr_valid = |d_valid_in;
    for (int k = N_CH; k >= 1; k--) begin
      idx  = (int'(ptr) + k) % N_CH;
      cand = SEL_W'(idx);
      if (d_valid_in[cand]) begin
        rr_g = cand;
      end
    end
  end

  // Final grant. Holding reset suppresses the grant, so no producer sees
  // ready while the slot is held empty.
  always_comb begin
    g           = mode_in ? rr_g : sel_in;
    grant_valid = rst_n_in && (mode_in ? rr_valid : fx_valid);
    take        = grant_valid && space;
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (g == SEL_W'(i)) begin
        g_data = ch_data[i];
      end
    end
  end

  always_comb begin
    d_ready_out = '0;
    for (int i = 0; i < N_CH; i++) begin
      d_ready_out[i] = take && (g == SEL_W'(i));
    end
  end

  // Output slot and pointer. A load takes priority over a drain, which gives
  // back-to-back beats with no bubble. The pointer follows every grant, in
  // either mode, so rotation stays fair across mode switches.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      d_valid_out <= 1'b0;
      d_out       <= '0;
      ch_out      <= '0;
      ptr         <= SEL_W'(N_CH - 1);
    end else if (take) begin
      d_valid_out <= 1'b1;
      d_out       <= g_data;
      ch_out      <= g;
      ptr         <= g;
    end else if (d_ready_in) begin
      d_valid_out <= 1'b0;
    end
  end

endmodule
